// File: rtl/lin_interp_pkg.sv
// lin_interp_pkg: shared widths, defaults and state encoding for the interpolator
package lin_interp_pkg;
    localparam int ADC_WIDTH_DEF = 8;
    localparam int INTERP_DEPTH_DEF = 4;
    localparam int SAMPLE_PERIOD_DEF = 4;
    localparam int ACC_W = ADC_WIDTH_DEF + INTERP_DEPTH_DEF + 1;
    localparam int DELTA_W = ADC_WIDTH_DEF + 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    function automatic int acc_w(input int aw, input int n);
        return aw + n + 1;
    endfunction

    function automatic int delta_w(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/lin_interp_tick.sv
// sample_tick_gen: free-running divider, tick high on the last count of each period
module sample_tick_gen #(
    parameter int SAMPLE_PERIOD = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    logic [CW-1:0] cnt;

    always_comb tick = cnt == CW'(SAMPLE_PERIOD - 1);

    always_ff @(posedge clk) begin
        if (!rstn) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/lin_interp.sv
// lin_interp: upsampler emitting 2^INTERP_DEPTH_BITS linearly interpolated strobed samples per input
module lin_interp
    import lin_interp_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEF,
    parameter int INTERP_DEPTH_BITS = INTERP_DEPTH_DEF,
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ADC_WIDTH-1:0] data_in,
    input  logic                 data_in_valid,
    output logic [ADC_WIDTH-1:0] interp_data_out,
    output logic                 sample,
    output logic                 underrun,
    output logic                 overrun
);
    localparam int N = INTERP_DEPTH_BITS;
    localparam int AW = acc_w(ADC_WIDTH, N);
    localparam int DW = delta_w(ADC_WIDTH);

    logic tick, pend, seg_end, start;
    state_t state;
    logic [N-1:0] step;
    logic [ADC_WIDTH-1:0] pend_data, prev, curr, prev_new;
    logic signed [AW-1:0] acc, acc_step;
    logic signed [DW-1:0] delta, delta_new;

    sample_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk (clk),
        .rstn(rstn),
        .tick(tick)
    );

    // a pending input only starts a segment once the current one has emitted all its strobes
    always_comb begin
        seg_end = &step;
        start = tick && pend && (state != RUN || seg_end);
        prev_new = (state == IDLE) ? pend_data : curr;
        delta_new = $signed({1'b0, pend_data}) - $signed({1'b0, prev_new});
        acc_step = acc + $signed({{N{delta[DW-1]}}, delta});
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            step <= '0;
            pend <= 1'b0;
            pend_data <= '0;
            prev <= '0;
            curr <= '0;
            acc <= '0;
            delta <= '0;
            interp_data_out <= '0;
            sample <= 1'b0;
            underrun <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sample <= 1'b0;
            underrun <= 1'b0;
            overrun <= data_in_valid && pend && !start;
            pend <= data_in_valid || (pend && !start);
            if (data_in_valid) pend_data <= data_in;
            if (start) begin
                prev <= prev_new;
                curr <= pend_data;
                delta <= delta_new;
                acc <= AW'({prev_new, N'(0)});
                interp_data_out <= prev_new;
                step <= '0;
                sample <= 1'b1;
                state <= RUN;
            end else if (tick && state == RUN && !seg_end) begin
                acc <= acc_step;
                interp_data_out <= acc_step[ADC_WIDTH+N-1:N];
                step <= step + 1'b1;
                sample <= 1'b1;
            end else if (tick && state != IDLE) begin
                state <= HOLD;
                interp_data_out <= curr;
                sample <= 1'b1;
                underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lin_interp.sv
// tb_lin_interp: randomized + directed scoreboard bench for lin_interp (W=8, N=2, P=4)
module tb_lin_interp;
    localparam int W = 8;
    localparam int N = 2;
    localparam int P = 4;
    localparam int L = 1 << N;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [W-1:0] data_in = '0;
    logic data_in_valid = 1'b0;
    logic [W-1:0] interp_data_out;
    logic sample, underrun, overrun;

    int n_chk = 0;
    int n_fail = 0;

    int exp_d[$];
    bit exp_u[$];
    int seg[$];
    bit exp_s = 0, exp_o = 0, started = 0, pend = 0, run_chk = 0;
    int cyc = 0, pend_val = 0, curr = 0;

    lin_interp #(.ADC_WIDTH(W), .INTERP_DEPTH_BITS(N), .SAMPLE_PERIOD(P)) dut (
        .clk(clk),
        .rstn(rstn),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .interp_data_out(interp_data_out),
        .sample(sample),
        .underrun(underrun),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // reference model: segment-level view, one queue entry per expected strobe
    always @(posedge clk) begin
        bit tick, consume;
        int p;
        if (!rstn) begin
            cyc = 0; pend = 0; started = 0; exp_s = 0; exp_o = 0;
            seg.delete(); exp_d.delete(); exp_u.delete();
        end else begin
            cyc++;
            tick = (cyc % P) == 0;
            exp_s = 0;
            consume = tick && pend && seg.size() == 0;
            exp_o = data_in_valid && pend && !consume;
            if (tick) begin
                if (seg.size() > 0) begin
                    exp_d.push_back(seg.pop_front()); exp_u.push_back(0); exp_s = 1;
                end else if (pend) begin
                    p = started ? curr : pend_val;
                    curr = pend_val;
                    for (int k = 0; k < L; k++) begin
                        if (k == 0) begin
                            exp_d.push_back(p); exp_u.push_back(0);
                        end else seg.push_back(fdiv(p * L + k * (curr - p), L));
                    end
                    exp_s = 1; started = 1; pend = 0;
                end else if (started) begin
                    exp_d.push_back(curr); exp_u.push_back(1); exp_s = 1;
                end
            end
            if (data_in_valid) begin
                pend = 1; pend_val = int'(data_in);
            end
        end
    end

    always @(negedge clk) begin
        int d;
        bit u;
        if (run_chk) begin
            n_chk++;
            if (sample !== exp_s) begin
                n_fail++;
                $display("FAIL strobe: got %0b want %0b at %0t", sample, exp_s, $time);
            end
            n_chk++;
            if (overrun !== exp_o) begin
                n_fail++;
                $display("FAIL overrun: got %0b want %0b at %0t", overrun, exp_o, $time);
            end
            if (sample) begin
                n_chk++;
                if (exp_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_strobe: got data %0d want no strobe at %0t", interp_data_out, $time);
                end else begin
                    d = exp_d.pop_front(); u = exp_u.pop_front();
                    if (int'(interp_data_out) != d) begin
                        n_fail++;
                        $display("FAIL data: got %0d want %0d at %0t", interp_data_out, d, $time);
                    end
                    n_chk++;
                    if (underrun !== u) begin
                        n_fail++;
                        $display("FAIL underrun_strobe: got %0b want %0b at %0t", underrun, u, $time);
                    end
                end
            end else begin
                if (exp_s && exp_d.size() > 0) begin
                    d = exp_d.pop_front(); u = exp_u.pop_front();
                end
                n_chk++;
                if (underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL underrun_idle: got %0b want 0 at %0t", underrun, $time);
                end
            end
            if (!started) begin
                n_chk++;
                if (interp_data_out !== '0) begin
                    n_fail++;
                    $display("FAIL idle_data: got %0d want 0 at %0t", interp_data_out, $time);
                end
            end
        end
    end

    task automatic send(input int v, input int gap);
        data_in = W'(v);
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        run_chk = 1;
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        send(0, 16); send(100, 16);
        send(200, 16); send(100, 16); send(3, 16);
        repeat (40) @(negedge clk);
        send(40, 20);
        send(50, 6); send(10, 3); send(20, 30);
        send(90, 13);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 300; i++)
            send($urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(1, 30));
        repeat (40) @(negedge clk);
        n_chk++;
        if (exp_d.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d strobes outstanding want 0", exp_d.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lin_interp.md
Name: lin_interp

Overview:
- Upsampling linear interpolator; the inverse direction of the box-average decimator.
- Accepts low-rate samples marked by a single-cycle valid pulse and emits 2^INTERP_DEPTH_BITS linearly interpolated samples per input.
- Each output sample is qualified by a one-clock "sample" strobe, the same strobe convention the averager consumes.
- Sits between the control/DSP path and the DAC or gate-drive reference path.

Parameters:
- ADC_WIDTH, 8, bit width of input and output samples (unsigned).
- INTERP_DEPTH_BITS, 4, log2 of the interpolation factor; must be ≥1.
- SAMPLE_PERIOD, 4, clocks per output strobe; must be ≥2 so the strobe has a low phase.

Ports:
- clk  in  1  sample-rate clock
- rstn  in  1  synchronous active-low reset
- data_in  in  ADC_WIDTH  low-rate input sample
- data_in_valid  in  1  single-cycle pulse; data_in is good on this cycle
- interp_data_out  out  ADC_WIDTH  interpolated output sample
- sample  out  1  one-clock strobe; interp_data_out is valid from this cycle until the next strobe
- underrun  out  1  one-clock pulse: strobe issued in HOLD (no new input ready)
- overrun  out  1  one-clock pulse: pending input overwritten before it was used

Behaviour:
- Reset (rstn=0 at a clk edge): interp_data_out=0, sample=0, underrun=0, overrun=0, state=IDLE, tick counter=0, step=0, pend=0, prev=curr=acc=delta=0.
- Tick generator:
  - free-running counter 0..SAMPLE_PERIOD-1, counting from the first clock after reset.
  - tick is high when count==SAMPLE_PERIOD-1.
- Input capture:
  - data_in_valid loads pend_data<=data_in and sets pend=1, in any state.
  - If pend is already 1 and not being consumed that cycle: overwrite pend_data and pulse overrun.
  - If valid coincides with the consuming tick, the consumed value is the old pend_data and the new one becomes pending; no overrun.
- Segment start (tick && pend && state∈{IDLE, HOLD, RUN with step==2^N-1}):
  - From IDLE: prev<=pend_data, curr<=pend_data.
  - Otherwise: prev<=curr, curr<=pend_data.
  - delta<=curr_new-prev_new, signed ADC_WIDTH+1 bits.
  - acc<=prev_new<<N; interp_data_out<=prev_new; step<=0; pend<=0; sample=1; state<=RUN.
- RUN tick with step<2^N-1:
  - acc<=acc+delta; interp_data_out<=(acc+delta)>>N (floor); step<=step+1; sample=1.
- RUN tick with step==2^N-1 and no pend:
  - state<=HOLD; interp_data_out<=curr; sample=1; underrun=1.
- HOLD tick without pend: interp_data_out holds curr; sample=1; underrun=1.
- IDLE tick without pend: no strobe; output stays 0.
- Pending input never truncates a running segment; every segment emits exactly 2^N strobes.
- Arithmetic:
  - acc is signed ADC_WIDTH+N+1 bits.
  - Output is acc[ADC_WIDTH+N-1:N], which is always in range, so no saturation is needed.
  - Division by 2^N truncates toward −inf.
- Latency: a valid arriving in IDLE/HOLD produces its first strobe at the next tick (1..SAMPLE_PERIOD clocks).
- sample, underrun and overrun are registered and high for exactly one clock.
- Mid-operation reset: everything returns to reset values on that edge; the pending sample is discarded.

Decomposition:
- Shared package holds:
  - default ADC_WIDTH
  - the derived width constants ACC_W = ADC_WIDTH+INTERP_DEPTH_BITS+1 and DELTA_W = ADC_WIDTH+1
  - state encoding IDLE/RUN/HOLD
- One sub-module: sample_tick_gen (parameter SAMPLE_PERIOD; ports clk, rstn, tick), reusable by other strobe producers.

Test Plan:
All scenarios use ADC_WIDTH=8, INTERP_DEPTH_BITS=2, SAMPLE_PERIOD=4, with valid every 16 clocks unless stated.
- Reset: rstn low 3 cycles, then no input for 40 clocks -> sample never asserts; interp_data_out=0; no underrun.
- Ramp up: inputs 0, 100 -> strobes 0,0,0,0 then 0,25,50,75, then 100 on following segment start.
- Ramp down with rounding: inputs 200, 100, 3 -> 200×4, 200,175,150,125, then 100,75,51,27 (floor of −97/4 steps).
- Underrun: inputs 0, 100, then stop -> after 0,25,50,75 every tick gives 100 with underrun=1 each strobe; a late 40 restarts at 100,85,70,55.
- Overrun: in RUN, valid 10 then valid 20, 3 clocks apart -> overrun one pulse; next segment interpolates toward 20; 10 never appears as an endpoint.
- Reset mid-RUN: assert rstn low at step 2 -> next cycle all outputs 0, state IDLE, no strobes until a new valid.
